// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and sequencer states.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/rca4.sv
// 4-bit ripple-carry adder stage; the only carry chain the sequencer ever exercises in one cycle.
module rca4
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
        assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_seq_adder.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single rca4,
// LS nibble first, with the inter-nibble carry held in carry_q.
module nibble_seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = $clog2(NIBBLES);

    seq_state_t state_q, state_next;

    logic [IDX_W-1:0]    idx_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                carry_q;

    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];
    logic [NIBBLE_W-1:0] stage_sum;
    logic                stage_cout;
    logic                last_nib;

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi] = a_q[gi*NIBBLE_W +: NIBBLE_W];
        assign b_nib[gi] = b_q[gi*NIBBLE_W +: NIBBLE_W];
    end

    rca4 u_rca4 (
        .a    (a_nib[idx_q]),
        .b    (b_nib[idx_q]),
        .cin  (carry_q),
        .sum  (stage_sum),
        .cout (stage_cout)
    );

    assign last_nib  = (idx_q == IDX_W'(NIBBLES - 1));
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_nib)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Subtraction is folded in at accept time so RUN only ever adds.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        sum     <= '0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum[idx_q*NIBBLE_W +: NIBBLE_W] <= stage_sum;
                    carry_q <= stage_cout;
                    if (last_nib) begin
                        idx_q    <= '0;
                        cout     <= stage_cout;
                        // Final MSB comes straight from the stage; sum is not yet updated here.
                        overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                    (stage_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Directed bench for nibble_seq_adder (WIDTH=16): arithmetic, latency, backpressure, reset abort, issue rate.
module tb_nibble_seq_adder;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb,
                         input string tag);
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        chk({tag, ".sum"}, 32'(sum), 32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
    endtask

    task automatic pop(input string tag, input logic [15:0] es);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".pop_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".pop_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".sum_kept"}, 32'(sum), 32'(es));
    endtask

    task automatic directed_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                               input logic ci, input logic sb,
                               input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        issue(av, bv, ci, sb, tag);
        wait_valid(lat);
        chk({tag, ".latency"}, 32'(lat), 32'd4);
        check_res(tag, es, ec, eo);
        $display("op %s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                 tag, av, bv, ci, sb, sum, cout, overflow, lat);
        pop(tag, es);
    endtask

    initial begin
        int lat;
        int acc [3];
        logic [15:0] ba [3];
        logic [15:0] bb [3];
        logic [15:0] bs [3];
        logic        bc [3];
        logic        bo [3];

        // Reset state
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        check_res("rst", 16'h0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        // Arithmetic and boundary cases
        directed_op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        directed_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed_op("add_ripple_cin", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        directed_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Backpressure: result held, new operands refused while DONE
        issue(16'h4321, 16'h1111, 1'b0, 1'b0, "bp");
        wait_valid(lat);
        chk("bp.latency", 32'(lat), 32'd4);
        a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_ready", 32'(in_ready), 32'd0);
            check_res("bp.hold", 16'h5432, 1'b0, 1'b0);
        end
        $display("op bp: held sum=%h cout=%b ovf=%b for 3 cycles", sum, cout, overflow);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.idle_ready", 32'(in_ready), 32'd1);
        chk("bp.idle_valid", 32'(out_valid), 32'd0);
        chk("bp.sum_kept", 32'(sum), 32'h5432);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk("bp2.latency", 32'(lat), 32'd4);
        check_res("bp2", 16'h0003, 1'b0, 1'b0);
        $display("op bp2: a=0001 b=0002 -> sum=%h cout=%b ovf=%b lat=%0d", sum, cout, overflow, lat);
        pop("bp2", 16'h0003);

        // Asynchronous reset after two nibbles aborts the operation
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, "abort");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort.mid_valid", 32'(out_valid), 32'd0);
        n_rst = 1'b0;
        #1;
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        check_res("abort", 16'h0000, 1'b0, 1'b0);
        $display("op abort: reset mid-RUN -> sum=%h out_valid=%b in_ready=%b", sum, out_valid, in_ready);
        #2 n_rst = 1'b1;
        @(posedge clk); #1;
        directed_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Back-to-back issue with both handshakes tied high
        ba = '{16'hABCD, 16'h8000, 16'h1000};
        bb = '{16'h1234, 16'h8000, 16'h0001};
        bs = '{16'hBE01, 16'h0000, 16'h0FFF};
        bc = '{1'b0, 1'b1, 1'b1};
        bo = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = ba[i]; b = bb[i]; cin = 1'b0; sub = (i == 2);
            chk("b2b.in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            acc[i] = cyc;
            wait_valid(lat);
            chk("b2b.latency", 32'(lat), 32'd4);
            check_res("b2b", bs[i], bc[i], bo[i]);
            $display("op b2b%0d: a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b accept_cyc=%0d",
                     i, ba[i], bb[i], sub, sum, cout, overflow, acc[i]);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b.gap01", 32'(acc[1] - acc[0]), 32'd6);
        chk("b2b.gap12", 32'(acc[2] - acc[1]), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
